// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store stage: operation codes and FSM states.
package load_store_unit_pkg;

  localparam logic [3:0] kNOP = 4'h0;
  localparam logic [3:0] kCPP = 4'h1;
  localparam logic [3:0] kADD = 4'h2;
  localparam logic [3:0] kSUB = 4'h3;
  localparam logic [3:0] kLOD = 4'h8;
  localparam logic [3:0] kSTR = 4'h9;

  typedef enum logic [1:0] {IDLE, LD_RD, LD_WB, ST_WR} lsu_state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == kLOD) || (op == kSTR);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Control-side request/response bundle of the load/store stage.
interface load_store_unit_if #(
  parameter int W = 8,
  parameter int A = 4
);
  logic         Start;
  logic [3:0]   Operation;
  logic [W-1:0] Addr;
  logic [W-1:0] StoreData;
  logic [A-1:0] Rtaddr;
  logic         Stall;
  logic         WbEn;
  logic [A-1:0] WbAddr;
  logic [W-1:0] WbData;
  logic         Err;
  logic [15:0]  AccessCount;

  modport master (
    output Start, Operation, Addr, StoreData, Rtaddr,
    input  Stall, WbEn, WbAddr, WbData, Err, AccessCount
  );

  modport slave (
    input  Start, Operation, Addr, StoreData, Rtaddr,
    output Stall, WbEn, WbAddr, WbData, Err, AccessCount
  );
endinterface

// File: rtl/load_store_unit_data_mem.sv
// Single-port data memory: synchronous write, registered read, contents not reset.
module data_mem #(
  parameter int W  = 8,
  parameter int DA = 8
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [DA-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [0:(1<<DA)-1];

  always_ff @(posedge Clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage between the register file and the data memory.
//   state | meaning
//   IDLE  | no access in flight, requests accepted
//   LD_RD | latched address presented to memory, read registered
//   LD_WB | write-back strobe to register file; new request may be accepted
//   ST_WR | latched data written to latched address at end of cycle
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int W  = 8,
  parameter int DA = 8,
  parameter int A  = 4
) (
  input logic              Clk,
  input logic              Reset,
  load_store_unit_if.slave bus
);

  lsu_state_t    state;
  logic [DA-1:0] lat_addr;
  logic [W-1:0]  lat_data;
  logic [A-1:0]  lat_rt;
  logic          wb_en;
  logic [A-1:0]  wb_addr;
  logic          err;
  logic [15:0]   access_count;

  logic          req_valid;
  logic          busy;
  logic          accept;
  logic          mem_we;
  logic [W-1:0]  mem_q;

  assign req_valid = bus.Start && is_mem_op(bus.Operation);
  // LD_WB only drives the write-back, so the stage is free to take the next request.
  assign busy      = (state == LD_RD) || (state == ST_WR);
  assign accept    = req_valid && !busy;
  assign mem_we    = (state == ST_WR) && !Reset;

  if (DA < W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.Addr[W-1:DA];
  end

  data_mem #(.W(W), .DA(DA)) u_data_mem (
    .Clk   (Clk),
    .we    (mem_we),
    .addr  (lat_addr),
    .wdata (lat_data),
    .rdata (mem_q)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      lat_addr     <= '0;
      lat_data     <= '0;
      lat_rt       <= '0;
      wb_en        <= 1'b0;
      wb_addr      <= '0;
      err          <= 1'b0;
      access_count <= '0;
    end else begin
      wb_en <= 1'b0;
      if ((state == LD_WB) || (state == ST_WR)) access_count <= access_count + 16'd1;
      if (req_valid && busy) err <= 1'b1;

      case (state)
        LD_RD: begin
          state   <= LD_WB;
          wb_en   <= 1'b1;
          wb_addr <= lat_rt;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        lat_addr <= bus.Addr[DA-1:0];
        if (bus.Operation == kLOD) begin
          state  <= LD_RD;
          lat_rt <= bus.Rtaddr;
        end else begin
          state    <= ST_WR;
          lat_data <= bus.StoreData;
        end
      end
    end
  end

  assign bus.Stall       = busy || req_valid;
  assign bus.WbEn        = wb_en;
  assign bus.WbAddr      = wb_addr;
  assign bus.WbData      = wb_en ? mem_q : '0;
  assign bus.Err         = err;
  assign bus.AccessCount = access_count;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized traffic against a transaction-level model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int W  = 8;
  localparam int DA = 6;
  localparam int A  = 4;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  load_store_unit_if #(.W(W), .A(A)) bus ();
  load_store_unit #(.W(W), .DA(DA), .A(A)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: a request is accepted unless the previous accepted one began exactly one cycle ago.
  logic [W-1:0]  m_mem   [1<<DA];
  bit            m_known [1<<DA];
  int            m_busy_cyc = -1;
  int            m_wb_cyc   = -1;
  int            m_st_cyc   = -1;
  logic [A-1:0]  m_wb_rt;
  logic [W-1:0]  m_wb_data;
  bit            m_wb_known;
  logic [DA-1:0] m_st_addr;
  logic [W-1:0]  m_st_data;
  bit            m_err;
  logic [15:0]   m_cnt;
  bit            m_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge Clk) begin
    if (Reset) begin
      m_busy_cyc = -1;
      m_wb_cyc   = -1;
      m_st_cyc   = -1;
      m_err      = 1'b0;
      m_cnt      = '0;
      m_ready    = 1'b1;
    end else if (m_ready) begin
      if (m_st_cyc == cyc) begin
        m_mem[m_st_addr]   = m_st_data;
        m_known[m_st_addr] = 1'b1;
        m_cnt++;
      end
      if (m_wb_cyc == cyc) m_cnt++;
      if (bus.Start && is_mem_op(bus.Operation)) begin
        if (m_busy_cyc == cyc) m_err = 1'b1;
        else begin
          m_busy_cyc = cyc + 1;
          if (bus.Operation == kLOD) begin
            m_wb_cyc   = cyc + 2;
            m_wb_rt    = bus.Rtaddr;
            m_wb_data  = m_mem[bus.Addr[DA-1:0]];
            m_wb_known = m_known[bus.Addr[DA-1:0]];
          end else begin
            m_st_cyc  = cyc + 1;
            m_st_addr = bus.Addr[DA-1:0];
            m_st_data = bus.StoreData;
          end
        end
      end
    end
    cyc++;
  end

  always @(negedge Clk) begin
    if (m_ready) begin
      chk("stall", bus.Stall, (m_busy_cyc == cyc) || (bus.Start && is_mem_op(bus.Operation)));
      chk("wben", bus.WbEn, m_wb_cyc == cyc);
      if (m_wb_cyc == cyc) begin
        chk("wbaddr", bus.WbAddr, m_wb_rt);
        if (m_wb_known) chk("wbdata", bus.WbData, m_wb_data);
      end
      chk("err", bus.Err, m_err);
      chk("count", bus.AccessCount, m_cnt);
    end
  end

  task automatic drive(input logic s, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] d, input logic [3:0] rt, input logic r = 1'b0);
    bus.Start     = s;
    bus.Operation = op;
    bus.Addr      = a;
    bus.StoreData = d;
    bus.Rtaddr    = rt;
    Reset         = r;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0);
      tick();
    end
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    drive(1'b1, kSTR, a, d, 4'h0);
    tick();
    idle(1);
  endtask

  // Issues a load and returns WbData from its write-back cycle; flags a missing strobe.
  task automatic load(input logic [7:0] a, input logic [3:0] rt, output logic [7:0] q);
    drive(1'b1, kLOD, a, 8'h00, rt);
    tick();
    idle(1);
    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0);
    chk("load_strobe", bus.WbEn, 1'b1);
    q = bus.WbData;
    tick();
  endtask

  logic [7:0] q;
  int         nstall;
  logic [15:0] exp_wrap [4];

  initial begin
    exp_wrap[0] = 16'hFFFE;
    exp_wrap[1] = 16'hFFFF;
    exp_wrap[2] = 16'h0000;
    exp_wrap[3] = 16'h0001;

    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0, 1'b1);
    tick();
    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0, 1'b1);
    tick();
    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0);
    chk("rst_stall", bus.Stall, 1'b0);
    chk("rst_wben", bus.WbEn, 1'b0);
    chk("rst_wbaddr", bus.WbAddr, 4'h0);
    chk("rst_wbdata", bus.WbData, 8'h00);
    chk("rst_err", bus.Err, 1'b0);
    chk("rst_count", bus.AccessCount, 16'h0000);
    tick();

    // store then load two cycles later
    drive(1'b1, kSTR, 8'h10, 8'hA5, 4'h0);
    chk("st_stall_c0", bus.Stall, 1'b1);
    tick();
    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0);
    chk("st_stall_c1", bus.Stall, 1'b1);
    tick();
    drive(1'b1, kLOD, 8'h10, 8'h00, 4'h4);
    tick();
    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0);
    chk("ld_stall_c1", bus.Stall, 1'b1);
    tick();
    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0);
    chk("ld_wben_c2", bus.WbEn, 1'b1);
    chk("ld_wbaddr", bus.WbAddr, 4'h4);
    chk("ld_wbdata", bus.WbData, 8'hA5);
    chk("ld_stall_c2", bus.Stall, 1'b0);
    tick();
    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0);
    chk("st_ld_count", bus.AccessCount, 16'd2);
    tick();

    // non-memory op
    drive(1'b1, kCPP, 8'h10, 8'h33, 4'h2);
    chk("cpp_stall", bus.Stall, 1'b0);
    tick();
    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0);
    chk("cpp_wben", bus.WbEn, 1'b0);
    chk("cpp_err", bus.Err, 1'b0);
    chk("cpp_count", bus.AccessCount, 16'd2);
    tick();

    // busy collision
    store(8'h20, 8'h5A);
    drive(1'b1, kLOD, 8'h10, 8'h00, 4'h7);
    tick();
    drive(1'b1, kSTR, 8'h20, 8'hC3, 4'h0);
    tick();
    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0);
    chk("col_wben", bus.WbEn, 1'b1);
    chk("col_wbdata", bus.WbData, 8'hA5);
    tick();
    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0);
    chk("col_err", bus.Err, 1'b1);
    chk("col_count", bus.AccessCount, 16'd4);
    tick();
    load(8'h20, 4'h1, q);
    chk("col_mem_kept", q, 8'h5A);
    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0);
    chk("col_err_sticky", bus.Err, 1'b1);
    tick();

    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0, 1'b1);
    tick();

    // reset mid-load
    drive(1'b1, kLOD, 8'h10, 8'h00, 4'h9);
    tick();
    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0, 1'b1);
    tick();
    nstall = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0);
      if (bus.WbEn) nstall++;
      tick();
    end
    chk("rstld_no_wben", nstall, 0);
    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0);
    chk("rstld_count", bus.AccessCount, 16'd0);
    chk("rstld_wbaddr", bus.WbAddr, 4'h0);
    tick();
    load(8'h10, 4'h3, q);
    chk("rstld_mem_kept", q, 8'hA5);

    // reset mid-store
    store(8'h30, 8'h11);
    drive(1'b1, kSTR, 8'h30, 8'h77, 4'h0);
    tick();
    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0, 1'b1);
    tick();
    load(8'h30, 4'h5, q);
    chk("rstst_suppressed", q, 8'h11);

    // address wraps modulo depth
    store(8'hC5, 8'h3C);
    load(8'h05, 4'h6, q);
    chk("addr_wrap", q, 8'h3C);

    // back-to-back loads across the counter wrap
    idle(2);
    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0);
    force dut.access_count = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #1;
    release dut.access_count;
    tick();
    for (int k = 0; k < 4; k++) begin
      nstall = 0;
      drive(1'b1, kLOD, 8'h10, 8'h00, 4'(k));
      chk("wrap_count", bus.AccessCount, exp_wrap[k]);
      if (bus.Stall) nstall++;
      tick();
      for (int j = 0; j < 2; j++) begin
        drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0);
        if (bus.Stall) nstall++;
        tick();
      end
      chk("b2b_stall_cycles", nstall, 2);
    end
    drive(1'b0, kNOP, 8'h00, 8'h00, 4'h0);
    chk("wrap_final", bus.AccessCount, 16'h0002);
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic       s;
      logic [3:0] op;
      int         pick;
      s    = ($urandom_range(0, 9) < 5);
      pick = $urandom_range(0, 5);
      op   = (pick < 2) ? kLOD : (pick < 4) ? kSTR : (pick == 4) ? kCPP : 4'($urandom_range(0, 15));
      drive(s, op, {2'($urandom), 6'($urandom_range(0, 7))}, 8'($urandom), 4'($urandom),
            ($urandom_range(0, 99) == 0));
      tick();
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, limit 1000000 reached");
    $fatal(1);
  end

endmodule
